mbist_resp_cmp: RTL and testbench
=================================

Name: mbist_resp_cmp

Overview:
- Read-side response analyzer for the SRAM MBIST.
- Receives read data returned from the SRAM during a BIST run.
- Regenerates the expected pattern from the same PAT_SEL/gen_Turn encoding the write-data generator uses, and compares the two.
- Accumulates pass/fail status, a failure count and first-failure diagnostics, then presents a final result to the BIST controller.

Parameters:
- ADDR_W, 8: width of the SRAM read address.
- CNT_W, 8: width of the saturating failure counter.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- nRESET  input  1  synchronous, active-low reset.
- CMP_EN  input  1  comparator enable; high for the whole BIST run.
- PAT_SEL  input  3  pattern select: 0 MSCAN, 1 checkerboard, 2 March C, others no-compare.
- gen_Turn  input  4  current test phase, same encoding as the write generator.
- RD_VALID  input  1  RD_DATA/RD_ADDR are valid this cycle.
- RD_ADDR  input  ADDR_W  address of the returned read data.
- RD_DATA  input  8  data read from the SRAM.
- TEST_END  input  1  one-cycle pulse from the controller: run finished.
- RES_CLR  input  1  clear results and return to IDLE.
- ERR_PULSE  output  1  registered one-cycle pulse per mismatching compare.
- FAIL  output  1  sticky: at least one mismatch since the last clear.
- FAIL_CNT  output  CNT_W  number of mismatches, saturating at all-ones.
- FIRST_ADDR  output  ADDR_W  RD_ADDR of the first mismatch.
- FIRST_DATA  output  8  RD_DATA of the first mismatch.
- RESULT_VALID  output  1  high in DONE; results are final.
- PASS  output  1  equal to RESULT_VALID & ~FAIL.

Behaviour:
- Reset: when nRESET is low at a rising edge, every output and register goes to 0 and the state goes to IDLE. Reset has priority over all other inputs, including during a run.
- States:
  - IDLE: enter ACTIVE when CMP_EN=1.
  - ACTIVE:
    - TEST_END=1 -> DONE.
    - CMP_EN=0 without TEST_END -> IDLE; results are held, not cleared.
  - DONE: RESULT_VALID=1; results are frozen and RD_VALID is ignored. Leave only on RES_CLR -> IDLE.
- RES_CLR in any state: on the next edge, clear FAIL, FAIL_CNT, FIRST_*, ERR_PULSE and RESULT_VALID, and go to IDLE. RES_CLR has priority over TEST_END and RD_VALID in the same cycle.
- A compare happens only in ACTIVE, with RD_VALID=1 and a defined expected value. Result is registered with 1-cycle latency: ERR_PULSE, FAIL, FAIL_CNT and FIRST_* update at the edge after the sampled cycle.
- Expected data (even address = RD_ADDR[0]==0):
  - PAT_SEL 0: gen_Turn 2 -> 8'h00; gen_Turn 4 -> 8'h01; other turns no compare.
  - PAT_SEL 1: gen_Turn<3 -> even 8'hAA, odd 8'h55; gen_Turn>=3 -> even 8'h55, odd 8'hAA.
  - PAT_SEL 2: gen_Turn 2, 4, 6 -> 8'h00; gen_Turn 3, 5 -> 8'h01; other turns no compare.
  - PAT_SEL 3-7: never compare; ERR_PULSE stays 0.
- Mismatch means any bit of RD_DATA XOR expected is 1.
  - ERR_PULSE=1 for exactly one cycle per mismatch.
  - FAIL is set.
  - FAIL_CNT increments and holds at 2^CNT_W-1 once reached.
- FIRST_ADDR/FIRST_DATA are captured only when FAIL was 0 before the compare. Later mismatches never overwrite them.
- A TEST_END arriving in the same cycle as a final RD_VALID: that compare is still evaluated and included in the DONE results.
- Back-to-back RD_VALID every cycle is supported, with no stalls.
- X/Z on RD_DATA counts as a mismatch in simulation, i.e. the compare uses !== semantics.

Optional Feature:
- Macro: MBIST_RESP_CMP_DIAG_EN.
- Defined:
  - Adds output FAIL_BITMAP[7:0]: the bitwise OR of (RD_DATA XOR expected) over all compares since the last clear.
  - Updates on the same edge as FAIL, clears on reset or RES_CLR, and is frozen in DONE.
- Undefined: the port is absent and no diagnostic logic is built.

Test Plan:
1. PAT_SEL=1, gen_Turn=1, reads addr 0..7 returning AA/55 alternating, then TEST_END -> ERR_PULSE never high, FAIL_CNT=0, RESULT_VALID=1, PASS=1.
2. PAT_SEL=2, gen_Turn=3, addr 5 returns 8'h03, all others 8'h01 -> one ERR_PULSE one cycle after the read, FAIL=1, FAIL_CNT=1, FIRST_ADDR=5, FIRST_DATA=8'h03, PASS=0 after TEST_END; with the macro, FAIL_BITMAP=8'h02.
3. PAT_SEL=0, gen_Turn=4, 300 consecutive reads of 8'hFF with CNT_W=8 -> FAIL_CNT saturates at 255, FIRST_ADDR is the first read address, ERR_PULSE high every cycle.
4. PAT_SEL=3, arbitrary read data -> no ERR_PULSE, PASS=1 at TEST_END; then RES_CLR and TEST_END in the same cycle -> state IDLE, RESULT_VALID=0.
5. nRESET driven low mid-run after 2 failures -> on the next edge all outputs are 0 and the state is IDLE. Repeat with nRESET low while RES_CLR and RD_VALID are asserted -> reset wins.
6. In DONE, drive RD_VALID with mismatching data -> FAIL_CNT and FIRST_* unchanged, ERR_PULSE stays 0.

Source files
------------

// File: rtl/mbist_resp_cmp.sv
// Read-side MBIST response analyzer: regenerates expected SRAM data, compares it with read data
// and accumulates pass/fail diagnostics. Optional sticky bit map via MBIST_RESP_CMP_DIAG_EN.
module mbist_resp_cmp #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              CMP_EN,
  input  logic [2:0]        PAT_SEL,
  input  logic [3:0]        gen_Turn,
  input  logic              RD_VALID,
  input  logic [ADDR_W-1:0] RD_ADDR,
  input  logic [7:0]        RD_DATA,
  input  logic              TEST_END,
  input  logic              RES_CLR,
  output logic              ERR_PULSE,
  output logic              FAIL,
  output logic [CNT_W-1:0]  FAIL_CNT,
  output logic [ADDR_W-1:0] FIRST_ADDR,
  output logic [7:0]        FIRST_DATA,
  output logic              RESULT_VALID,
  output logic              PASS
`ifdef MBIST_RESP_CMP_DIAG_EN
  ,
  output logic [7:0]        FAIL_BITMAP
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_r;

  logic [8:0] exp_s;
  logic [7:0] exp_data_s;
  logic [7:0] diff_s;
  logic       cmp_s;
  logic       mismatch_s;

  // Returns {compare_valid, expected_byte} for the pattern/phase/address parity.
  function automatic logic [8:0] exp_lookup(input logic [2:0] pat, input logic [3:0] turn,
                                            input logic odd);
    logic [8:0] r;
    r = 9'd0;
    case (pat)
      3'd0: begin
        case (turn)
          4'd2:    r = {1'b1, 8'h00};
          4'd4:    r = {1'b1, 8'h01};
          default: r = 9'd0;
        endcase
      end
      3'd1: begin
        if (turn < 4'd3) r = odd ? {1'b1, 8'h55} : {1'b1, 8'hAA};
        else             r = odd ? {1'b1, 8'hAA} : {1'b1, 8'h55};
      end
      3'd2: begin
        case (turn)
          4'd2, 4'd4, 4'd6: r = {1'b1, 8'h00};
          4'd3, 4'd5:       r = {1'b1, 8'h01};
          default:          r = 9'd0;
        endcase
      end
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  // Compare qualification; the 4-state inequality makes X/Z read data count as a failure.
  always_comb begin
    exp_s      = exp_lookup(PAT_SEL, gen_Turn, RD_ADDR[0]);
    exp_data_s = exp_s[7:0];
    diff_s     = RD_DATA ^ exp_data_s;
    cmp_s      = (state_r == ACTIVE) && RD_VALID && exp_s[8];
    mismatch_s = 1'b0;
    if (cmp_s) mismatch_s = (RD_DATA !== exp_data_s);
    else       mismatch_s = 1'b0;
  end

  // Run-state tracking and result accumulation.
  always_ff @(posedge CLK) begin
    if (!nRESET || RES_CLR) begin
      state_r      <= IDLE;
      ERR_PULSE    <= 1'b0;
      FAIL         <= 1'b0;
      FAIL_CNT     <= {CNT_W{1'b0}};
      FIRST_ADDR   <= {ADDR_W{1'b0}};
      FIRST_DATA   <= 8'h00;
      RESULT_VALID <= 1'b0;
      PASS         <= 1'b0;
`ifdef MBIST_RESP_CMP_DIAG_EN
      FAIL_BITMAP  <= 8'h00;
`endif
    end else begin
      ERR_PULSE <= mismatch_s;
      if (mismatch_s) begin
        FAIL <= 1'b1;
        if (FAIL_CNT != {CNT_W{1'b1}}) FAIL_CNT <= FAIL_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
        if (!FAIL) begin
          FIRST_ADDR <= RD_ADDR;
          FIRST_DATA <= RD_DATA;
        end
      end
`ifdef MBIST_RESP_CMP_DIAG_EN
      if (cmp_s) FAIL_BITMAP <= FAIL_BITMAP | diff_s;
`endif
      case (state_r)
        IDLE: begin
          if (CMP_EN) state_r <= ACTIVE;
          else        state_r <= IDLE;
        end
        ACTIVE: begin
          // A read arriving with TEST_END is folded into the final verdict.
          if (TEST_END) begin
            state_r      <= DONE;
            RESULT_VALID <= 1'b1;
            PASS         <= ~(FAIL | mismatch_s);
          end else if (!CMP_EN) begin
            state_r <= IDLE;
          end else begin
            state_r <= ACTIVE;
          end
        end
        DONE:    state_r <= DONE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_resp_cmp.sv
// Directed self-checking bench for mbist_resp_cmp; covers the optional bit map when
// MBIST_RESP_CMP_DIAG_EN is defined.
module tb_mbist_resp_cmp;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       CMP_EN = 1'b0;
  logic [2:0] PAT_SEL = 3'd0;
  logic [3:0] gen_Turn = 4'd0;
  logic       RD_VALID = 1'b0;
  logic [7:0] RD_ADDR = 8'h00;
  logic [7:0] RD_DATA = 8'h00;
  logic       TEST_END = 1'b0;
  logic       RES_CLR = 1'b0;
  logic       ERR_PULSE;
  logic       FAIL;
  logic [7:0] FAIL_CNT;
  logic [7:0] FIRST_ADDR;
  logic [7:0] FIRST_DATA;
  logic       RESULT_VALID;
  logic       PASS;
`ifdef MBIST_RESP_CMP_DIAG_EN
  logic [7:0] FAIL_BITMAP;
`endif

  int errors = 0;
  int checks = 0;

  mbist_resp_cmp #(.ADDR_W(8), .CNT_W(8)) dut (
    .CLK(CLK), .nRESET(nRESET), .CMP_EN(CMP_EN), .PAT_SEL(PAT_SEL), .gen_Turn(gen_Turn),
    .RD_VALID(RD_VALID), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .TEST_END(TEST_END),
    .RES_CLR(RES_CLR), .ERR_PULSE(ERR_PULSE), .FAIL(FAIL), .FAIL_CNT(FAIL_CNT),
    .FIRST_ADDR(FIRST_ADDR), .FIRST_DATA(FIRST_DATA), .RESULT_VALID(RESULT_VALID), .PASS(PASS)
`ifdef MBIST_RESP_CMP_DIAG_EN
    , .FAIL_BITMAP(FAIL_BITMAP)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear;
    RES_CLR = 1'b1;
    tick();
    RES_CLR = 1'b0;
  endtask

  task automatic test_reset;
    logic [27:0] all_s;
    nRESET = 1'b0;
    tick();
    tick();
    all_s = {ERR_PULSE, FAIL, FAIL_CNT, FIRST_ADDR, FIRST_DATA, RESULT_VALID, PASS};
    checks++;
    if (all_s !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_s);
    end
    nRESET = 1'b1;
  endtask

  task automatic test_checkerboard_pass;
    int bad;
    bad = 0;
    CMP_EN = 1'b1; PAT_SEL = 3'd1; gen_Turn = 4'd1;
    tick();
    for (int a = 0; a < 8; a++) begin
      RD_VALID = 1'b1; RD_ADDR = 8'(a);
      RD_DATA = (a % 2 == 1) ? 8'h55 : 8'hAA;
      tick();
      if (ERR_PULSE !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ckb_err_pulse: got %0d pulses expected 0", bad); end
    RD_VALID = 1'b0; TEST_END = 1'b1;
    tick();
    TEST_END = 1'b0;
    checks++;
    if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL ckb_result_valid: got %b expected 1", RESULT_VALID); end
    checks++;
    if (PASS !== 1'b1) begin errors++; $display("FAIL ckb_pass: got %b expected 1", PASS); end
    checks++;
    if (FAIL_CNT !== 8'd0) begin errors++; $display("FAIL ckb_fail_cnt: got %0d expected 0", FAIL_CNT); end
  endtask

  task automatic test_march_single_fail;
    do_clear();
    PAT_SEL = 3'd2; gen_Turn = 4'd3;
    tick();
    for (int a = 0; a < 8; a++) begin
      RD_VALID = 1'b1; RD_ADDR = 8'(a);
      RD_DATA = (a == 5) ? 8'h03 : 8'h01;
      tick();
      checks++;
      if (ERR_PULSE !== (a == 5)) begin
        errors++;
        $display("FAIL march_err_pulse addr %0d: got %b expected %b", a, ERR_PULSE, (a == 5));
      end
    end
    RD_VALID = 1'b0; TEST_END = 1'b1;
    tick();
    TEST_END = 1'b0;
    checks++;
    if (FAIL !== 1'b1) begin errors++; $display("FAIL march_fail: got %b expected 1", FAIL); end
    checks++;
    if (FAIL_CNT !== 8'd1) begin errors++; $display("FAIL march_fail_cnt: got %0d expected 1", FAIL_CNT); end
    checks++;
    if (FIRST_ADDR !== 8'd5) begin errors++; $display("FAIL march_first_addr: got %h expected 05", FIRST_ADDR); end
    checks++;
    if (FIRST_DATA !== 8'h03) begin errors++; $display("FAIL march_first_data: got %h expected 03", FIRST_DATA); end
    checks++;
    if (PASS !== 1'b0 || RESULT_VALID !== 1'b1) begin
      errors++; $display("FAIL march_verdict: got pass=%b valid=%b expected pass=0 valid=1", PASS, RESULT_VALID);
    end
`ifdef MBIST_RESP_CMP_DIAG_EN
    checks++;
    if (FAIL_BITMAP !== 8'h02) begin errors++; $display("FAIL march_bitmap: got %h expected 02", FAIL_BITMAP); end
`endif
  endtask

  task automatic test_done_frozen;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      RD_VALID = 1'b1; RD_ADDR = 8'h09; RD_DATA = 8'hFF;
      tick();
      if (ERR_PULSE !== 1'b0) bad++;
    end
    RD_VALID = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL done_err_pulse: got %0d pulses expected 0", bad); end
    checks++;
    if (FAIL_CNT !== 8'd1) begin errors++; $display("FAIL done_fail_cnt: got %0d expected 1", FAIL_CNT); end
    checks++;
    if (FIRST_ADDR !== 8'd5 || FIRST_DATA !== 8'h03) begin
      errors++; $display("FAIL done_first: got %h/%h expected 05/03", FIRST_ADDR, FIRST_DATA);
    end
    checks++;
    if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL done_result_valid: got %b expected 1", RESULT_VALID); end
`ifdef MBIST_RESP_CMP_DIAG_EN
    checks++;
    if (FAIL_BITMAP !== 8'h02) begin errors++; $display("FAIL done_bitmap: got %h expected 02", FAIL_BITMAP); end
`endif
  endtask

  task automatic test_end_with_read;
    do_clear();
    checks++;
    if (RESULT_VALID !== 1'b0 || FAIL !== 1'b0) begin
      errors++; $display("FAIL clear_state: got valid=%b fail=%b expected 0/0", RESULT_VALID, FAIL);
    end
    PAT_SEL = 3'd2; gen_Turn = 4'd3;
    tick();
    RD_VALID = 1'b1; RD_ADDR = 8'h02; RD_DATA = 8'h00; TEST_END = 1'b1;
    tick();
    RD_VALID = 1'b0; TEST_END = 1'b0;
    checks++;
    if (ERR_PULSE !== 1'b1) begin errors++; $display("FAIL end_read_err_pulse: got %b expected 1", ERR_PULSE); end
    checks++;
    if (FAIL_CNT !== 8'd1 || FIRST_ADDR !== 8'h02) begin
      errors++; $display("FAIL end_read_diag: got cnt=%0d addr=%h expected 1/02", FAIL_CNT, FIRST_ADDR);
    end
    checks++;
    if (PASS !== 1'b0 || RESULT_VALID !== 1'b1) begin
      errors++; $display("FAIL end_read_verdict: got pass=%b valid=%b expected 0/1", PASS, RESULT_VALID);
    end
  endtask

  task automatic test_mscan_saturate;
    int bad;
    bad = 0;
    do_clear();
    PAT_SEL = 3'd0; gen_Turn = 4'd4;
    tick();
    for (int i = 0; i < 300; i++) begin
      RD_VALID = 1'b1; RD_ADDR = 8'h10 + 8'(i); RD_DATA = 8'hFF;
      tick();
      if (ERR_PULSE !== 1'b1) bad++;
      if (i == 253) begin
        checks++;
        if (FAIL_CNT !== 8'd254) begin errors++; $display("FAIL mscan_cnt_254: got %0d expected 254", FAIL_CNT); end
      end
    end
    RD_VALID = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mscan_err_pulse: got %0d missing pulses expected 0", bad); end
    checks++;
    if (FAIL_CNT !== 8'd255) begin errors++; $display("FAIL mscan_saturate: got %0d expected 255", FAIL_CNT); end
    checks++;
    if (FIRST_ADDR !== 8'h10 || FIRST_DATA !== 8'hFF) begin
      errors++; $display("FAIL mscan_first: got %h/%h expected 10/ff", FIRST_ADDR, FIRST_DATA);
    end
`ifdef MBIST_RESP_CMP_DIAG_EN
    checks++;
    if (FAIL_BITMAP !== 8'hFE) begin errors++; $display("FAIL mscan_bitmap: got %h expected fe", FAIL_BITMAP); end
`endif
    tick();
    checks++;
    if (ERR_PULSE !== 1'b0) begin errors++; $display("FAIL mscan_pulse_drop: got %b expected 0", ERR_PULSE); end
  endtask

  task automatic test_no_compare_and_clear;
    int bad;
    bad = 0;
    do_clear();
    PAT_SEL = 3'd3; gen_Turn = 4'd2;
    tick();
    for (int i = 0; i < 6; i++) begin
      RD_VALID = 1'b1; RD_ADDR = 8'(i); RD_DATA = 8'(i * 37 + 5);
      tick();
      if (ERR_PULSE !== 1'b0) bad++;
    end
    RD_VALID = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL nocmp_err_pulse: got %0d pulses expected 0", bad); end
    TEST_END = 1'b1;
    tick();
    TEST_END = 1'b0;
    checks++;
    if (PASS !== 1'b1 || RESULT_VALID !== 1'b1) begin
      errors++; $display("FAIL nocmp_verdict: got pass=%b valid=%b expected 1/1", PASS, RESULT_VALID);
    end
    RES_CLR = 1'b1; TEST_END = 1'b1;
    tick();
    RES_CLR = 1'b0; TEST_END = 1'b0;
    checks++;
    if (RESULT_VALID !== 1'b0 || PASS !== 1'b0) begin
      errors++; $display("FAIL clr_vs_end: got valid=%b pass=%b expected 0/0", RESULT_VALID, PASS);
    end
    // A mismatching read right after the clear must be ignored because the block is idle.
    PAT_SEL = 3'd1; gen_Turn = 4'd1;
    RD_VALID = 1'b1; RD_ADDR = 8'h00; RD_DATA = 8'h00;
    tick();
    RD_VALID = 1'b0;
    checks++;
    if (ERR_PULSE !== 1'b0) begin errors++; $display("FAIL clr_idle_no_cmp: got %b expected 0", ERR_PULSE); end
  endtask

  task automatic test_reset_midrun;
    logic [27:0] all_s;
    do_clear();
    PAT_SEL = 3'd1; gen_Turn = 4'd5;
    tick();
    RD_VALID = 1'b1; RD_ADDR = 8'h00; RD_DATA = 8'hAA;
    tick();
    RD_ADDR = 8'h01; RD_DATA = 8'h55;
    tick();
    checks++;
    if (FAIL_CNT !== 8'd2) begin errors++; $display("FAIL midrun_cnt: got %0d expected 2", FAIL_CNT); end
    RD_ADDR = 8'h02; RD_DATA = 8'h00; nRESET = 1'b0;
    tick();
    all_s = {ERR_PULSE, FAIL, FAIL_CNT, FIRST_ADDR, FIRST_DATA, RESULT_VALID, PASS};
    checks++;
    if (all_s !== 28'd0) begin errors++; $display("FAIL midrun_reset: got %h expected 0", all_s); end
    nRESET = 1'b1; RD_VALID = 1'b0;
    tick();
    RD_VALID = 1'b1; RD_ADDR = 8'h03; RD_DATA = 8'h00;
    tick();
    checks++;
    if (FAIL_CNT !== 8'd1) begin errors++; $display("FAIL midrun_restart_cnt: got %0d expected 1", FAIL_CNT); end
    nRESET = 1'b0; RES_CLR = 1'b1; RD_ADDR = 8'h04; RD_DATA = 8'h00;
    tick();
    all_s = {ERR_PULSE, FAIL, FAIL_CNT, FIRST_ADDR, FIRST_DATA, RESULT_VALID, PASS};
    checks++;
    if (all_s !== 28'd0) begin errors++; $display("FAIL reset_wins: got %h expected 0", all_s); end
    nRESET = 1'b1; RES_CLR = 1'b0; RD_ADDR = 8'h06; RD_DATA = 8'h00;
    tick();
    RD_VALID = 1'b0;
    checks++;
    if (ERR_PULSE !== 1'b0) begin errors++; $display("FAIL reset_idle_no_cmp: got %b expected 0", ERR_PULSE); end
  endtask

  initial begin
    test_reset();
    test_checkerboard_pass();
    test_march_single_fail();
    test_done_frozen();
    test_end_with_read();
    test_mscan_saturate();
    test_no_compare_and_clear();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
